// File: rtl/riscv_dmem_responder.sv
// Data-memory slave for the single-cycle core: word RAM plus an MMIO block with a TX byte FIFO
// and a free-running cycle counter (counter present only when DMEM_CYCLE_COUNTER_EN is defined).
module riscv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned RAM_BYTES = DEPTH_WORDS * 4;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_RSVD   = 2'd3
  } mmio_reg_e;

  // Address decode; byte offset bits are ignored (word access only)
  logic       ram_hit;
  logic       mmio_hit;
  logic [AW-1:0] ram_idx;
  mmio_reg_e  reg_sel;

  assign ram_hit  = (addr < 32'(RAM_BYTES));
  assign mmio_hit = !ram_hit && (addr[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = addr[AW+1:2];
  assign reg_sel  = mmio_reg_e'(addr[3:2]);

  logic push_req;
  logic status_wr;

  assign push_req  = mem_write && mmio_hit && (reg_sel == REG_TXDATA);
  assign status_wr = mem_write && mmio_hit && (reg_sel == REG_STATUS);

  // Word RAM: contents survive reset
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (mem_write && ram_hit) begin
      mem[ram_idx] <= write_data;
    end
  end

  // TX FIFO control state
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && tx_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (status_wr) begin
      ovf_d = 1'b0;
    end else if (push_req && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage is cleared on reset so tx_data reads 0 while idle after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= write_data[7:0];
    end
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_q[rd_ptr_q];

  // Cycle counter: a write wins over the increment in the same cycle
  logic [31:0] cycle_val;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic        cycle_wr;
  logic [31:0] cycle_q, cycle_d;

  assign cycle_wr = mem_write && mmio_hit && (reg_sel == REG_CYCLE);

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (cycle_wr) begin
      cycle_d = write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // Combinational read mux
  logic [7:0] status;

  assign status = {1'b0, 4'(count_q), ovf_q, fifo_full, fifo_empty};

  always_comb begin
    read_data = '0;
    if (ram_hit) begin
      read_data = mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_STATUS: read_data = {24'h0, status};
        REG_CYCLE:  read_data = cycle_val;
        default:    read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed table-driven bench for riscv_dmem_responder (RAM, TX FIFO, CYCLE, unmapped, reset).
module tb_riscv_dmem_responder;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  localparam logic [31:0] A_TX  = 32'h0000_1000;
  localparam logic [31:0] A_ST  = 32'h0000_1004;
  localparam logic [31:0] A_CYC = 32'h0000_1008;
  localparam logic [31:0] A_RSV = 32'h0000_100C;

  riscv_dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                     input logic chk_rd, input logic [31:0] exp_rd, input logic exp_v,
                     input logic [7:0] exp_d);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_v = exp_v; v.exp_d = exp_d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    mem_write = we; addr = a; write_data = wd; tx_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // RAM, FIFO overflow/drain, push+pop at full, STATUS ovf clear, unmapped accesses
    add(0, A_ST,  0, 0, 1, 32'h01, 0, 8'h00);
    add(1, 32'h14, 32'h1111_1111, 0, 0, 0, 0, 8'h00);
    add(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 8'h00);
    add(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0, 8'h00);
    add(0, 32'h13, 0, 0, 1, 32'hDEAD_BEEF, 0, 8'h00);
    add(0, 32'h14, 0, 0, 1, 32'h1111_1111, 0, 8'h00);
    add(1, A_TX, 32'h41, 0, 1, 0, 0, 8'h00);
    add(1, A_TX, 32'h42, 0, 1, 0, 1, 8'h41);
    add(1, A_TX, 32'h43, 0, 1, 0, 1, 8'h41);
    add(1, A_TX, 32'h44, 0, 1, 0, 1, 8'h41);
    add(1, A_TX, 32'h45, 0, 1, 0, 1, 8'h41);
    add(0, A_ST, 0, 0, 1, 32'h26, 1, 8'h41);
    add(0, A_ST, 0, 1, 1, 32'h26, 1, 8'h41);
    add(0, A_ST, 0, 1, 1, 32'h1C, 1, 8'h42);
    add(0, A_ST, 0, 1, 1, 32'h14, 1, 8'h43);
    add(0, A_ST, 0, 1, 1, 32'h0C, 1, 8'h44);
    add(0, A_ST, 0, 1, 1, 32'h05, 0, 8'h00);
    add(1, A_ST, 32'hFFFF_FFFF, 0, 1, 32'h05, 0, 8'h00);
    add(0, A_ST, 0, 0, 1, 32'h01, 0, 8'h00);
    add(1, A_TX, 32'h61, 0, 1, 0, 0, 8'h00);
    add(1, A_TX, 32'h62, 0, 1, 0, 1, 8'h61);
    add(1, A_TX, 32'h63, 0, 1, 0, 1, 8'h61);
    add(1, A_TX, 32'h64, 0, 1, 0, 1, 8'h61);
    add(0, A_ST, 0, 0, 1, 32'h22, 1, 8'h61);
    add(1, A_TX, 32'h55, 1, 1, 0, 1, 8'h61);
    add(0, A_ST, 0, 0, 1, 32'h22, 1, 8'h62);
    add(0, A_ST, 0, 1, 1, 32'h22, 1, 8'h62);
    add(0, A_ST, 0, 1, 1, 32'h18, 1, 8'h63);
    add(0, A_ST, 0, 1, 1, 32'h10, 1, 8'h64);
    add(0, A_ST, 0, 1, 1, 32'h08, 1, 8'h55);
    add(0, A_ST, 0, 1, 1, 32'h01, 0, 8'h00);
    add(0, 32'h2000, 0, 0, 1, 0, 0, 8'h00);
    add(0, A_RSV, 0, 0, 1, 0, 0, 8'h00);
    add(1, 32'h2000, 32'hFFFF_FFFF, 0, 1, 0, 0, 8'h00);
    add(1, A_RSV, 32'hFFFF_FFFF, 0, 1, 0, 0, 8'h00);
    add(0, A_ST, 0, 0, 1, 32'h01, 0, 8'h00);
    add(0, 32'h2000, 0, 0, 1, 0, 0, 8'h00);
    add(0, A_RSV, 0, 0, 1, 0, 0, 8'h00);
    add(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0, 8'h00);

    reset = 1'b0;
    drive(0, A_ST, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    check("reset_status", read_data, 32'h01);
    reset = 1'b1;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
      @(negedge clk);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_d));
      next_cycle();
    end

    // CYCLE load and wrap
    drive(1, A_CYC, 32'hFFFF_FFFE, 0);
    next_cycle();
    drive(0, A_CYC, 0, 0);
`ifdef DMEM_CYCLE_COUNTER_EN
    @(negedge clk);
    check("cycle_load", read_data, 32'hFFFF_FFFE);
    next_cycle();
    @(negedge clk);
    check("cycle_inc", read_data, 32'hFFFF_FFFF);
    next_cycle();
    @(negedge clk);
    check("cycle_wrap", read_data, 32'h0000_0000);
    next_cycle();
`else
    @(negedge clk);
    check("cycle_absent", read_data, 32'h0);
    next_cycle();
`endif

    // Reset mid-drain
    drive(1, A_TX, 32'h71, 0);
    next_cycle();
    drive(1, A_TX, 32'h72, 0);
    next_cycle();
    drive(1, A_TX, 32'h73, 0);
    next_cycle();
    drive(0, A_ST, 0, 1);
    @(negedge clk);
    check("pre_reset_status", read_data, 32'h18);
    check("pre_reset_tx_data", 32'(tx_data), 32'h71);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_tx_valid", 32'(tx_valid), 32'h0);
    check("async_reset_status", read_data, 32'h01);
    check("async_reset_tx_data", 32'(tx_data), 32'h0);
    drive(0, 32'h10, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    check("ram_after_reset", read_data, 32'hDEAD_BEEF);
    check("idle_after_reset", 32'(tx_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
